// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a valid/ready handshake and a two-entry skid buffer.
// Handshake outputs are registered; a saturating counter records downstream stall cycles.
module pipe_stage_skid #(
    parameter int            DW     = 64,
    parameter logic [DW-1:0] BUBBLE = {DW{1'b0}},
    parameter int            CW     = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [DW-1:0] up_data,
    output logic          dn_valid,
    input  logic          dn_ready,
    output logic [DW-1:0] dn_data,
    output logic [1:0]    occupancy,
    output logic [CW-1:0] stall_cnt,
    input  logic          stall_cnt_clr
);

    // Handshake: a beat moves on a side exactly when valid and ready are both high
    // at the rising edge; valid never depends on ready, and up_ready is a register,
    // so dn_ready has no combinational path to up_ready.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] main_q;
    logic [DW-1:0] main_nxt;
    logic [DW-1:0] skid_q;
    logic [DW-1:0] skid_nxt;
    logic          acc;
    logic          iss;

    assign acc = up_valid & up_ready;
    assign iss = dn_valid & dn_ready;

    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (flush) begin
            // Flush wins over any same-cycle accept; an issue in this cycle still counts.
            state_nxt = EMPTY;
            main_nxt  = BUBBLE;
            skid_nxt  = BUBBLE;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (acc) begin
                        state_nxt = HALF;
                        main_nxt  = up_data;
                    end
                end
                HALF: begin
                    if (acc && !iss) begin
                        state_nxt = FULL;
                        skid_nxt  = up_data;
                    end else if (iss && !acc) begin
                        state_nxt = EMPTY;
                        main_nxt  = BUBBLE;
                    end else if (acc && iss) begin
                        main_nxt  = up_data;
                    end
                end
                FULL: begin
                    if (iss) begin
                        state_nxt = HALF;
                        main_nxt  = skid_q;
                        skid_nxt  = BUBBLE;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                    main_nxt  = BUBBLE;
                    skid_nxt  = BUBBLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= EMPTY;
            main_q   <= BUBBLE;
            skid_q   <= BUBBLE;
            dn_valid <= 1'b0;
            up_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            main_q   <= main_nxt;
            skid_q   <= skid_nxt;
            dn_valid <= (state_nxt != EMPTY);
            up_ready <= (state_nxt != FULL);
        end
    end

    assign dn_data   = main_q;
    assign occupancy = state;

    // Clear beats the increment; flush deliberately leaves the count alone.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt <= '0;
        end else if (stall_cnt_clr) begin
            stall_cnt <= '0;
        end else if (dn_valid && !dn_ready && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vector table, hand-written corner sequences,
// and random traffic checked against a queue-based reference model.
module tb_pipe_stage_skid;

    localparam int            DW  = 16;
    localparam int            CW  = 4;
    localparam logic [DW-1:0] BUB = 16'hB0B0;
    localparam int            SAT = (1 << CW) - 1;

    logic          clk;
    logic          rstn;
    logic          flush;
    logic          up_valid;
    logic          up_ready;
    logic [DW-1:0] up_data;
    logic          dn_valid;
    logic          dn_ready;
    logic [DW-1:0] dn_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;
    logic          stall_cnt_clr;

    pipe_stage_skid #(.DW(DW), .BUBBLE(BUB), .CW(CW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .flush        (flush),
        .up_valid     (up_valid),
        .up_ready     (up_ready),
        .up_data      (up_data),
        .dn_valid     (dn_valid),
        .dn_ready     (dn_ready),
        .dn_data      (dn_data),
        .occupancy    (occupancy),
        .stall_cnt    (stall_cnt),
        .stall_cnt_clr(stall_cnt_clr)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // reference model: held payloads in arrival order, plus the stall count
    logic [DW-1:0] exp_q[$];
    int            m_cnt;

    typedef struct {
        logic          uv;
        logic [DW-1:0] ud;
        logic          dr;
        logic          fl;
        logic          e_valid;
        logic [DW-1:0] e_data;
        logic          e_ready;
        logic [1:0]    e_occ;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic uv, input logic [DW-1:0] ud, input logic dr,
                                input logic fl, input logic ev, input logic [DW-1:0] ed,
                                input logic er, input logic [1:0] eo);
        vec_t v;
        v.uv = uv; v.ud = ud; v.dr = dr; v.fl = fl;
        v.e_valid = ev; v.e_data = ed; v.e_ready = er; v.e_occ = eo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check(input string tag);
        int sz;
        sz = exp_q.size();
        chk({tag, "_dn_valid"}, 64'(dn_valid), 64'(sz > 0));
        chk({tag, "_dn_data"}, 64'(dn_data), (sz > 0) ? 64'(exp_q[0]) : 64'(BUB));
        chk({tag, "_up_ready"}, 64'(up_ready), 64'(sz < 2));
        chk({tag, "_occupancy"}, 64'(occupancy), 64'(sz));
        chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(m_cnt));
    endtask

    task automatic model_step();
        int sz;
        sz = exp_q.size();
        if (stall_cnt_clr) m_cnt = 0;
        else if (sz > 0 && !dn_ready && m_cnt < SAT) m_cnt++;
        if (flush) begin
            exp_q.delete();
        end else begin
            if (sz > 0 && dn_ready) void'(exp_q.pop_front());
            if (up_valid && sz < 2) exp_q.push_back(up_data);
        end
    endtask

    // driver: called at a falling edge; checks, drives, crosses one rising edge
    task automatic cycle(input logic uv, input logic [DW-1:0] ud, input logic dr,
                         input logic fl, input logic clr, input string tag);
        model_check(tag);
        up_valid      = uv;
        up_data       = ud;
        dn_ready      = dr;
        flush         = fl;
        stall_cnt_clr = clr;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    initial begin
        rstn = 1'b1; flush = 1'b0; up_valid = 1'b0; up_data = '0;
        dn_ready = 1'b0; stall_cnt_clr = 1'b0;
        exp_q.delete();
        m_cnt = 0;
        #1 rstn = 1'b0;

        // reset state
        #11;
        chk("rst_up_ready", 64'(up_ready), 64'd1);
        chk("rst_dn_valid", 64'(dn_valid), 64'd0);
        chk("rst_dn_data", 64'(dn_data), 64'(BUB));
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        cycle(0, '0, 0, 0, 0, "idle");
        cycle(0, '0, 0, 0, 0, "idle");

        // streaming, back-pressure, flush-in-FULL
        for (int i = 1; i <= 8; i++) tbl.push_back(mk(1, DW'(i), 1, 0, 1, DW'(i), 1, 2'd1));
        tbl.push_back(mk(0, '0, 1, 0, 0, BUB, 1, 2'd0));
        tbl.push_back(mk(1, 16'h00AA, 0, 0, 1, 16'h00AA, 1, 2'd1));
        tbl.push_back(mk(1, 16'h00BB, 0, 0, 1, 16'h00AA, 0, 2'd2));
        tbl.push_back(mk(0, '0, 0, 0, 1, 16'h00AA, 0, 2'd2));
        tbl.push_back(mk(0, '0, 1, 0, 1, 16'h00BB, 1, 2'd1));
        tbl.push_back(mk(0, '0, 1, 0, 0, BUB, 1, 2'd0));
        tbl.push_back(mk(1, 16'h0A0A, 0, 0, 1, 16'h0A0A, 1, 2'd1));
        tbl.push_back(mk(1, 16'h0B0B, 0, 0, 1, 16'h0A0A, 0, 2'd2));
        tbl.push_back(mk(1, 16'h0C0C, 1, 1, 0, BUB, 1, 2'd0));
        tbl.push_back(mk(0, '0, 1, 0, 0, BUB, 1, 2'd0));

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].uv, tbl[i].ud, tbl[i].dr, tbl[i].fl, 0, "tbl");
            chk($sformatf("tbl%0d_dn_valid", i), 64'(dn_valid), 64'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_dn_data", i), 64'(dn_data), 64'(tbl[i].e_data));
            chk($sformatf("tbl%0d_up_ready", i), 64'(up_ready), 64'(tbl[i].e_ready));
            chk($sformatf("tbl%0d_occupancy", i), 64'(occupancy), 64'(tbl[i].e_occ));
        end

        // stall counter saturation and clear
        cycle(1, 16'h1234, 0, 0, 1, "stall_load");
        chk("stall_after_load_clr", 64'(stall_cnt), 64'd0);
        for (int i = 0; i < 20; i++) cycle(0, '0, 0, 0, 0, "stall_hold");
        chk("stall_saturated", 64'(stall_cnt), 64'(SAT));
        cycle(0, '0, 0, 0, 1, "stall_clr");
        chk("stall_cleared", 64'(stall_cnt), 64'd0);
        cycle(0, '0, 0, 0, 0, "stall_resume");
        chk("stall_restart", 64'(stall_cnt), 64'd1);
        cycle(0, '0, 1, 0, 0, "stall_drain");

        // async reset pulse in FULL, away from the clock edge
        cycle(1, 16'h5151, 0, 0, 0, "ar_fill");
        cycle(1, 16'h5252, 0, 0, 0, "ar_fill");
        chk("ar_full_occ", 64'(occupancy), 64'd2);
        up_valid = 1'b0; dn_ready = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("ar_dn_valid", 64'(dn_valid), 64'd0);
        chk("ar_up_ready", 64'(up_ready), 64'd1);
        chk("ar_occupancy", 64'(occupancy), 64'd0);
        chk("ar_dn_data", 64'(dn_data), 64'(BUB));
        chk("ar_stall_cnt", 64'(stall_cnt), 64'd0);
        exp_q.delete();
        m_cnt = 0;
        #1 rstn = 1'b1;
        cycle(1, 16'h6161, 1, 0, 0, "ar_resume");
        chk("ar_resume_data", 64'(dn_data), 64'h6161);
        cycle(1, 16'h6262, 1, 0, 0, "ar_resume");
        chk("ar_resume_data2", 64'(dn_data), 64'h6262);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0, "rnd");
        end
        cycle(0, '0, 1, 0, 0, "end");
        cycle(0, '0, 1, 0, 0, "end");
        model_check("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
